// File: rtl/instr_mem_responder.sv
// Byte-organised instruction memory answering CPU instruction fetches.
//
// A fetch request (READ with PC) is serviced by reading four consecutive
// bytes, one per cycle. They are assembled MSB-first into a 32-bit
// big-endian word. BUSYWAIT stalls the CPU until the word is available.
// A byte-wide load port writes the memory at any time.
//
// Ports:
//   CLK          system clock, rising-edge active
//   RESET        asynchronous active-low reset
//   PC           byte address of requested instruction (held while stalled)
//   READ         level-sensitive fetch request
//   BUSYWAIT     CPU stall, combinational: READ & (state != DONE)
//   INSTRUCTION  registered fetched word {mem[a], mem[a+1], mem[a+2], mem[a+3]}
//   ADDR_ERR     registered, high when last completed request was misaligned
//                or out of range
//   LOAD_EN      byte write strobe
//   LOAD_ADDR    byte write address
//   LOAD_DATA    byte write data
module instr_mem_responder #(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned ADDR_W      = 10
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       PC,
    input  logic              READ,
    output logic              BUSYWAIT,
    output logic [31:0]       INSTRUCTION,
    output logic              ADDR_ERR,
    input  logic              LOAD_EN,
    input  logic [ADDR_W-1:0] LOAD_ADDR,
    input  logic [7:0]        LOAD_DATA
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   base_q,  base_d;
    logic [WORD_W-1:0]   asm_q,   asm_d;
    logic [WORD_W-1:0]   instr_q, instr_d;
    logic                addr_err_q, addr_err_d;

    logic [BYTE_W-1:0]   mem_q [DEPTH_BYTES];
    logic [ADDR_W-1:0]   rd_addr;
    logic [BYTE_W-1:0]   rd_byte;
    logic                req_ok;

    // Byte storage; never reset so contents survive a CPU reset.
    always_ff @(posedge CLK) begin
        if (LOAD_EN) begin
            mem_q[LOAD_ADDR] <= LOAD_DATA;
        end
    end

    // Read port; a write to the same byte on this edge is seen next cycle.
    // An aligned in-range base plus 3 never leaves the array, so no wrap.
    assign rd_addr = base_q + ADDR_W'(count_q);
    assign rd_byte = mem_q[rd_addr];

    // Request is serviceable only when word-aligned and inside the array.
    assign req_ok = (PC[1:0] == 2'b00) && (PC < WORD_W'(DEPTH_BYTES));

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            count_q    <= '0;
            base_q     <= '0;
            asm_q      <= '0;
            instr_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            base_q     <= base_d;
            asm_q      <= asm_d;
            instr_q    <= instr_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        base_d     = base_q;
        asm_d      = asm_q;
        instr_d    = instr_q;
        addr_err_d = addr_err_q;

        unique case (state_q)
            IDLE: begin
                if (READ) begin
                    if (req_ok) begin
                        base_d  = PC[ADDR_W-1:0];
                        count_d = '0;
                        state_d = FETCH;
                    end else begin
                        // Rejected request: respond immediately, no memory access.
                        instr_d    = '0;
                        addr_err_d = 1'b1;
                        state_d    = DONE;
                    end
                end
            end

            FETCH: begin
                if (!READ) begin
                    // CPU withdrew the request: abandon the partial word.
                    count_d = '0;
                    state_d = IDLE;
                end else begin
                    asm_d   = {asm_q[WORD_W-BYTE_W-1:0], rd_byte};
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(3)) begin
                        instr_d    = {asm_q[WORD_W-BYTE_W-1:0], rd_byte};
                        addr_err_d = 1'b0;
                        count_d    = '0;
                        state_d    = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall drops only for the single DONE cycle of a request.
    assign BUSYWAIT    = READ & (state_q != DONE);
    assign INSTRUCTION = instr_q;
    assign ADDR_ERR    = addr_err_q;

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
Byte-organised instruction memory that answers the CPU's instruction fetch requests. The CPU presents PC with READ; the block assembles a 32-bit big-endian word from four consecutive bytes, one byte per cycle, and stalls the CPU with BUSYWAIT until the word is ready. A byte-wide load port fills the memory before and during execution.

Parameters:
DEPTH_BYTES, 1024, memory size in bytes; must be a multiple of 4.
ADDR_W, 10, byte address width; log2(DEPTH_BYTES).

Ports:
CLK  input  1  system clock; all state updates on rising edge.
RESET  input  1  asynchronous, active-low reset.
PC  input  32  byte address of the requested instruction; held stable by the CPU while BUSYWAIT=1.
READ  input  1  fetch request; level-sensitive.
BUSYWAIT  output  1  CPU stall; combinational.
INSTRUCTION  output  32  fetched word, registered; {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
ADDR_ERR  output  1  registered; high when the last completed request was misaligned or out of range.
LOAD_EN  input  1  byte write strobe.
LOAD_ADDR  input  ADDR_W  byte write address.
LOAD_DATA  input  8  byte write data.

Behaviour:
- Reset, when RESET=0 (asynchronous):
  - state=IDLE, byte count=0, assembly register=0, INSTRUCTION=32'h0, ADDR_ERR=0.
  - Memory contents are not cleared.
  - Reset during a fetch aborts the fetch.
- State machine states: IDLE, FETCH, DONE.
- Transitions from IDLE:
  - READ=1 with PC[1:0]==0 and PC<DEPTH_BYTES: latch PC[ADDR_W-1:0] as the base address; count=0; go to FETCH.
  - READ=1 with PC[1:0]!=0 or PC>=DEPTH_BYTES: INSTRUCTION<=32'h0, ADDR_ERR<=1, go to DONE. No memory read occurs.
  - READ=0: remain in IDLE.
- FETCH, on each edge:
  - Shift mem[base+count] into the assembly register, MSB byte first; count<=count+1.
  - On count==3: INSTRUCTION<=the complete word, ADDR_ERR<=0, go to DONE.
- DONE: go to IDLE on the next edge, unconditionally.
- Back-to-back fetches: if READ is still high in IDLE, a new fetch starts. Throughput is one word per 6 cycles.
- Latency: READ sampled at edge E0 → bytes read at E1..E4 → INSTRUCTION valid and state DONE after E4.
- BUSYWAIT = READ & (state!=DONE).
  - Rises in the same cycle READ rises.
  - Falls only during the DONE cycle.
  - Low whenever READ=0.
- READ dropped during FETCH: abort and return to IDLE on the next edge. INSTRUCTION and ADDR_ERR are unchanged and count resets to 0.
- PC changes while BUSYWAIT=1 are ignored, because the base address is latched.
- Load port:
  - LOAD_EN=1 writes LOAD_DATA to mem[LOAD_ADDR] at the edge, in any state.
  - Reading and writing the same byte in the same cycle returns the old byte; the new byte is visible from the next cycle.
- Address arithmetic: base+count never wraps, because an aligned base below DEPTH_BYTES plus 3 is always in range.
- INSTRUCTION holds its value between fetches.

Test Plan:
- Basic fetch: load bytes 0x01,0x02,0x03,0x04 at addresses 8..11; hold READ=1 with PC=8 → BUSYWAIT high for 5 cycles; after the 5th edge INSTRUCTION=32'h01020304, ADDR_ERR=0, and BUSYWAIT=0 for exactly one cycle.
- Misaligned and out-of-range requests:
  - PC=6, READ=1 → one cycle later INSTRUCTION=0, ADDR_ERR=1, BUSYWAIT low in DONE.
  - PC=1024 → same response.
  - A following aligned fetch at PC=8 clears ADDR_ERR.
- Abort: start a fetch at PC=8; drop READ after 2 cycles → state returns to IDLE; INSTRUCTION keeps its prior value; BUSYWAIT=0; a re-request at PC=12 returns the correct word after 5 edges.
- Reset mid-fetch: pull RESET low asynchronously (between clock edges) during FETCH → INSTRUCTION=0, BUSYWAIT=READ; after release, a fetch at PC=8 completes normally.
- Load/fetch collision:
  - Write 0xAA to address 9 in the same cycle byte 9 is read → the fetched word has the old byte 0x02.
  - A second fetch at PC=8 returns 32'h01AA0304.
- Back-to-back: hold READ=1 while stepping PC 0,4,8 → three words returned on 6-cycle spacing; BUSYWAIT low only in each DONE cycle.
